trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 15 +
 rtl/trap_ctrl_if.sv | 35 +++
 rtl/trap_ctrl_irq_edge_pend.sv | 29 ++
 rtl/trap_ctrl.sv | 135 +++++++++++++
 tb/tb_trap_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared widths and FSM encoding for the interrupt trap controller.
package trap_ctrl_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INT_NUM_DEF = 16;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_ENTRY   = 2'd2,
    ST_HANDLER = 2'd3
  } trap_state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of pipeline/CSR-side signals around the trap controller.
interface trap_ctrl_if import trap_ctrl_pkg::*; #(
  parameter int INT_NUM = INT_NUM_DEF
) ();

  logic [INT_NUM-1:0]  irq;
  logic                int_mstatus_mie;
  logic                pipe_drained;
  logic [PC_WIDTH-1:0] wb_pc;
  logic                mret_wb;

  logic                pipe_flush;
  logic                trap_entry_en;
  logic                trap_exit_en;
  logic [PC_WIDTH-1:0] normal_pc;
  logic [IDX_W-1:0]    int_index;
  logic                pc_redirect;
  logic                redirect_sel;
  logic [INT_NUM-1:0]  irq_ack;

  // Core/CSR side: drives requests and pipeline status, observes trap control.
  modport master (
    output irq, int_mstatus_mie, pipe_drained, wb_pc, mret_wb,
    input  pipe_flush, trap_entry_en, trap_exit_en, normal_pc,
           int_index, pc_redirect, redirect_sel, irq_ack
  );

  // Trap controller side.
  modport slave (
    input  irq, int_mstatus_mie, pipe_drained, wb_pc, mret_wb,
    output pipe_flush, trap_entry_en, trap_exit_en, normal_pc,
           int_index, pc_redirect, redirect_sel, irq_ack
  );

endinterface

// File: rtl/trap_ctrl_irq_edge_pend.sv
// Per-source rising-edge detector with a sticky pending bit.
module irq_edge_pend (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  input  logic clr_i,
  output logic pend_o
);

  logic prev_q;
  logic pend_q;

  // Track the previous level; a new rising edge takes precedence over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= irq_i;
      if (irq_i && !prev_q)
        pend_q <= 1'b1;
      else if (clr_i)
        pend_q <= 1'b0;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/trap_ctrl.sv
// Interrupt trap controller: pending capture, fixed-priority arbitration,
// and the flush/entry/handler sequencing toward the CSR file and fetch.
module trap_ctrl import trap_ctrl_pkg::*; #(
  parameter int INT_NUM = INT_NUM_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  trap_ctrl_if.slave bus
);

  trap_state_e         state_q, state_d;
  logic [IDX_W-1:0]    int_index_q, int_index_d;
  logic [PC_WIDTH-1:0] normal_pc_q, normal_pc_d;
  logic                entry_q, entry_d;
  logic                exit_q, exit_d;
  logic                redir_q, redir_d;
  logic                sel_q, sel_d;
  logic [INT_NUM-1:0]  ack_q, ack_d;

  logic [INT_NUM-1:0]  pend;
  logic [INT_NUM-1:0]  clr;
  logic [IDX_W-1:0]    win_idx;
  logic                win_vld;

  genvar gi;
  generate
    for (gi = 0; gi < INT_NUM; gi++) begin : g_src
      // The taken source is cleared at the end of its ENTRY cycle.
      assign clr[gi] = (state_q == ST_ENTRY) && (int_index_q == IDX_W'(gi));

      irq_edge_pend u_pend (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_i  (bus.irq[gi]),
        .clr_i  (clr[gi]),
        .pend_o (pend[gi])
      );
    end
  endgenerate

  // Fixed priority: scan from the top so the lowest pending index wins.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (pend[i]) begin
        win_idx = IDX_W'(i);
        win_vld = 1'b1;
      end
    end
  end

  // Next state plus next values of the registered trap outputs.
  always_comb begin
    state_d     = state_q;
    int_index_d = int_index_q;
    normal_pc_d = normal_pc_q;
    entry_d     = 1'b0;
    exit_d      = 1'b0;
    redir_d     = 1'b0;
    sel_d       = 1'b0;
    ack_d       = '0;
    case (state_q)
      ST_IDLE: begin
        // An mret with no active trap still restores mepc.
        if (bus.mret_wb) begin
          exit_d  = 1'b1;
          redir_d = 1'b1;
          sel_d   = 1'b1;
        end
        if (win_vld && bus.int_mstatus_mie) begin
          state_d     = ST_FLUSH;
          int_index_d = win_idx;
        end
      end
      ST_FLUSH: begin
        // Losing MIE aborts before drain is considered; pending is kept.
        if (!bus.int_mstatus_mie) begin
          state_d = ST_IDLE;
        end else if (bus.pipe_drained) begin
          state_d     = ST_ENTRY;
          entry_d     = 1'b1;
          redir_d     = 1'b1;
          normal_pc_d = bus.wb_pc;
          ack_d       = INT_NUM'(1) << int_index_q;
        end
      end
      ST_ENTRY: begin
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (bus.mret_wb) begin
          state_d = ST_IDLE;
          exit_d  = 1'b1;
          redir_d = 1'b1;
          sel_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight trap context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      int_index_q <= '0;
      normal_pc_q <= '0;
      entry_q     <= 1'b0;
      exit_q      <= 1'b0;
      redir_q     <= 1'b0;
      sel_q       <= 1'b0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      int_index_q <= int_index_d;
      normal_pc_q <= normal_pc_d;
      entry_q     <= entry_d;
      exit_q      <= exit_d;
      redir_q     <= redir_d;
      sel_q       <= sel_d;
      ack_q       <= ack_d;
    end
  end

  assign bus.pipe_flush    = (state_q == ST_FLUSH) || (state_q == ST_ENTRY);
  assign bus.trap_entry_en = entry_q;
  assign bus.trap_exit_en  = exit_q;
  assign bus.normal_pc     = normal_pc_q;
  assign bus.int_index     = int_index_q;
  assign bus.pc_redirect   = redir_q;
  assign bus.redirect_sel  = sel_q;
  assign bus.irq_ack       = ack_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with hand-computed expectations.
module tb_trap_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  trap_ctrl_if #(.INT_NUM(16)) bus ();

  trap_ctrl #(.INT_NUM(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ctl(input string tag, input logic flush, input logic entry,
                            input logic ex, input logic redir, input logic sel);
    check({tag, ".flush"}, 64'(bus.pipe_flush),    64'(flush));
    check({tag, ".entry"}, 64'(bus.trap_entry_en), 64'(entry));
    check({tag, ".exit"},  64'(bus.trap_exit_en),  64'(ex));
    check({tag, ".redir"}, 64'(bus.pc_redirect),   64'(redir));
    check({tag, ".sel"},   64'(bus.redirect_sel),  64'(sel));
  endtask

  // Pulse mret for one cycle from HANDLER and check the exit pulse.
  task automatic do_mret(input string tag);
    bus.mret_wb = 1'b1;
    tick();
    expect_ctl({tag, "_exit"}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    bus.mret_wb = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    bus.irq             = '0;
    bus.int_mstatus_mie = 1'b1;
    bus.pipe_drained    = 1'b1;
    bus.wb_pc           = 32'h100;
    bus.mret_wb         = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    expect_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.idx", 64'(bus.int_index), 64'h0);
    check("rst.npc", 64'(bus.normal_pc), 64'h0);
    check("rst.ack", 64'(bus.irq_ack),   64'h0);
    rst_n = 1'b1;

    // S1: single source, drained pipe, minimum latency
    bus.irq[5] = 1'b1;
    tick();
    expect_ctl("s1_set", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_ctl("s1_flush", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s1.idx", 64'(bus.int_index), 64'd5);
    tick();
    expect_ctl("s1_entry", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s1.ack", 64'(bus.irq_ack),   64'h0020);
    check("s1.npc", 64'(bus.normal_pc), 64'h100);
    tick();
    expect_ctl("s1_hdl", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s1.ack0", 64'(bus.irq_ack), 64'h0);
    bus.irq[5] = 1'b0;
    do_mret("s1");
    tick();
    expect_ctl("s1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // S2: simultaneous 2 and 9, lowest first, then 9 after mret
    bus.wb_pc  = 32'h200;
    bus.irq[2] = 1'b1;
    bus.irq[9] = 1'b1;
    tick();
    tick();
    check("s2.idx2", 64'(bus.int_index), 64'd2);
    tick();
    expect_ctl("s2_entry2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s2.ack2", 64'(bus.irq_ack),   64'h0004);
    check("s2.npc2", 64'(bus.normal_pc), 64'h200);
    tick();
    bus.irq   = '0;
    bus.wb_pc = 32'h300;
    do_mret("s2a");
    tick();
    expect_ctl("s2_flush9", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s2.idx9", 64'(bus.int_index), 64'd9);
    tick();
    expect_ctl("s2_entry9", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s2.ack9", 64'(bus.irq_ack),   64'h0200);
    check("s2.npc9", 64'(bus.normal_pc), 64'h300);
    tick();
    do_mret("s2b");
    tick();
    expect_ctl("s2_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // S3: abort in FLUSH (mie drop wins over same-cycle drain), retake later
    bus.pipe_drained = 1'b0;
    bus.irq[4] = 1'b1;
    tick();
    tick();
    expect_ctl("s3_flush", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_ctl("s3_stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.int_mstatus_mie = 1'b0;
    bus.pipe_drained    = 1'b1;
    tick();
    expect_ctl("s3_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s3.ack", 64'(bus.irq_ack), 64'h0);
    tick();
    expect_ctl("s3_masked", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.int_mstatus_mie = 1'b1;
    tick();
    expect_ctl("s3_reflush", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s3.idx", 64'(bus.int_index), 64'd4);
    tick();
    expect_ctl("s3_entry", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s3.ackx", 64'(bus.irq_ack), 64'h0010);
    bus.irq[4] = 1'b0;
    tick();
    do_mret("s3");
    tick();
    expect_ctl("s3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // S4: edge during HANDLER is held until after mret
    bus.irq[6] = 1'b1;
    tick();
    tick();
    tick();
    check("s4.idx6", 64'(bus.int_index), 64'd6);
    bus.irq[6] = 1'b0;
    tick();
    bus.irq[3] = 1'b1;
    tick();
    expect_ctl("s4_hdl1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_ctl("s4_hdl2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_mret("s4");
    tick();
    expect_ctl("s4_flush3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s4.idx3", 64'(bus.int_index), 64'd3);
    tick();
    expect_ctl("s4_entry3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("s4.ack3", 64'(bus.irq_ack), 64'h0008);
    bus.irq[3] = 1'b0;
    tick();
    do_mret("s4b");
    tick();
    expect_ctl("s4_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // S5: source 7 re-rises in its own ENTRY cycle, so it is taken again
    bus.irq[7] = 1'b1;
    tick();
    bus.irq[7] = 1'b0;
    tick();
    tick();
    check("s5.ack7", 64'(bus.irq_ack), 64'h0080);
    bus.irq[7] = 1'b1;
    tick();
    bus.irq[7] = 1'b0;
    do_mret("s5");
    tick();
    expect_ctl("s5_reflush", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s5.idx7", 64'(bus.int_index), 64'd7);
    tick();
    expect_ctl("s5_reentry", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    do_mret("s5b");
    tick();

    // S6: asynchronous reset mid-HANDLER drops the trap context
    bus.wb_pc  = 32'h440;
    bus.irq[1] = 1'b1;
    tick();
    bus.irq[1] = 1'b0;
    tick();
    tick();
    check("s6.npc", 64'(bus.normal_pc), 64'h440);
    tick();
    check("s6.idx", 64'(bus.int_index), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_ctl("s6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s6.rst_idx", 64'(bus.int_index), 64'h0);
    check("s6.rst_npc", 64'(bus.normal_pc), 64'h0);
    check("s6.rst_ack", 64'(bus.irq_ack),   64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    expect_ctl("s6_post1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_ctl("s6_post2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
